ch_pack: RTL and testbench

//  Downstream of the channel selector. While req_data is high, captures ch_data[sel] each cycle

---
 rtl/ch_pack_if.sv | 29 ++
 rtl/ch_pack.sv | 145 ++++++++++++++
 tb/tb_ch_pack.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ch_pack_if.sv
// Channel-capture / host-FIFO write bundle for ch_pack.
// The slave modport is the packer; the master modport drives the sample source and downstream status.
interface ch_pack_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NCH        = 8,
  parameter int unsigned DEPTH_LOG2 = 5
);
  logic                   req_data;
  logic [2:0]             sel;
  logic [NCH*WIDTH-1:0]   ch_data;
  logic                   wr_full;
  logic                   clr_ovf;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_en;
  logic                   wr_sop;
  logic                   ovf;
  logic [15:0]            ovf_cnt;
  logic [DEPTH_LOG2:0]    fill;

  modport master (
    output req_data, sel, ch_data, wr_full, clr_ovf,
    input  wr_data, wr_en, wr_sop, ovf, ovf_cnt, fill
  );

  modport slave (
    input  req_data, sel, ch_data, wr_full, clr_ovf,
    output wr_data, wr_en, wr_sop, ovf, ovf_cnt, fill
  );
endinterface

// File: rtl/ch_pack.sv
// Captures the selected channel sample, buffers it in a small FIFO and drains it as framed packets.
// Optional CH_PACK_SEQ_EN: each packet starts with a {8'hA5, seq} header word.
module ch_pack #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NCH        = 8,
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned PKT_WORDS  = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  ch_pack_if.slave    bus
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PCW   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  localparam logic [0:0] ST_SOP  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic                  r_cap_vld;
  logic [WIDTH-1:0]      r_cap_data;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_fill;
  logic [0:0]            r_state;
  logic [PCW-1:0]        r_pkt_cnt;
  logic                  r_wr_en;
  logic                  r_wr_sop;
  logic [WIDTH-1:0]      r_wr_data;
  logic                  r_ovf;
  logic [15:0]           r_ovf_cnt;
`ifdef CH_PACK_SEQ_EN
  logic [7:0]            r_seq;
`endif

  logic [WIDTH-1:0]      w_sample;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_hdr;
  logic                  w_pkt_last;

  always_comb begin
    w_sample = '0;
    if (32'(bus.sel) < NCH) begin
      w_sample = bus.ch_data[32'(bus.sel)*WIDTH +: WIDTH];
    end
  end

  assign w_full     = (r_fill == (DEPTH_LOG2+1)'(DEPTH));
  assign w_push     = r_cap_vld && !w_full;
  assign w_drop     = r_cap_vld && w_full;
  // A packet (header included) only starts once there is data to follow it.
  assign w_issue    = (r_fill != '0) && !bus.wr_full;
  assign w_pkt_last = (r_pkt_cnt == PCW'(PKT_WORDS - 1));
`ifdef CH_PACK_SEQ_EN
  assign w_hdr      = w_issue && (r_state == ST_SOP);
`else
  assign w_hdr      = 1'b0;
`endif
  assign w_pop      = w_issue && !w_hdr;

  // Storage has no reset; pointers and fill define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cap_vld  <= 1'b0;
      r_cap_data <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fill     <= '0;
      r_state    <= ST_SOP;
      r_pkt_cnt  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sop   <= 1'b0;
      r_wr_data  <= '0;
      r_ovf      <= 1'b0;
      r_ovf_cnt  <= '0;
`ifdef CH_PACK_SEQ_EN
      r_seq      <= '0;
`endif
    end else begin
      r_cap_vld <= bus.req_data;
      if (bus.req_data) begin
        r_cap_data <= w_sample;
      end

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 1'b1;
      end else if (!w_push && w_pop) begin
        r_fill <= r_fill - 1'b1;
      end

      r_wr_en  <= w_issue;
      r_wr_sop <= w_issue && (r_state == ST_SOP);
      if (w_pop) begin
        r_wr_data <= r_mem[r_rptr];
      end
`ifdef CH_PACK_SEQ_EN
      if (w_hdr) begin
        r_wr_data <= WIDTH'({8'hA5, r_seq});
        r_seq     <= r_seq + 1'b1;
      end
`endif

      if (w_issue) begin
        r_pkt_cnt <= w_pkt_last ? '0 : r_pkt_cnt + 1'b1;
        r_state   <= w_pkt_last ? ST_SOP : ST_DATA;
      end

      // Clear has priority over a simultaneous drop; the dropped word is still discarded.
      if (bus.clr_ovf) begin
        r_ovf     <= 1'b0;
        r_ovf_cnt <= '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != 16'hFFFF) begin
          r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.wr_data = r_wr_data;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_sop  = r_wr_sop;
  assign bus.ovf     = r_ovf;
  assign bus.ovf_cnt = r_ovf_cnt;
  assign bus.fill    = r_fill;

endmodule

// File: tb/tb_ch_pack.sv
// Scoreboard bench for ch_pack: expected words are queued at drive time and popped on wr_en.
module tb_ch_pack;
  localparam int PKT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ch_pack_if #(.WIDTH(16), .NCH(8), .DEPTH_LOG2(5)) bus ();

  ch_pack #(.WIDTH(16), .NCH(8), .DEPTH_LOG2(5), .PKT_WORDS(PKT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  int          exp_pkt = 0;
  logic [7:0]  exp_seq = 8'h00;
  int          n_data = 0;
  int          cur_run = 0;
  int          max_run = 0;
  logic        full_at_edge = 1'b0;
  logic [15:0] smp_base = 16'h2000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) full_at_edge <= bus.wr_full;

  always @(negedge clk) begin
    if (!reset_n) begin
      cur_run = 0;
    end else if (bus.wr_en) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      check_eq("wr_en_after_full", full_at_edge, 0);
      check_eq("wr_sop", bus.wr_sop, exp_pkt == 0);
`ifdef CH_PACK_SEQ_EN
      if (exp_pkt == 0) begin
        check_eq("header", bus.wr_data, {8'hA5, exp_seq});
        exp_seq++;
      end else
`endif
      if (exp_q.size() == 0) begin
        check_eq("extra_word", exp_q.size(), 1);
      end else begin
        check_eq("wr_data", bus.wr_data, exp_q.pop_front());
        n_data++;
      end
      exp_pkt = (exp_pkt + 1) % PKT;
    end else begin
      cur_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [15:0] base);
    for (int k = 0; k < 8; k++) bus.ch_data[k*16 +: 16] = base + 16'(k);
  endtask

  task automatic push_sample(input logic [2:0] s, input logic [15:0] base, input bit keep);
    set_data(base);
    bus.sel      = s;
    bus.req_data = 1'b1;
    if (keep) exp_q.push_back(base + 16'(s));
    tick();
  endtask

  task automatic idle(input int n);
    bus.req_data = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_drain(input string tag);
    bus.req_data = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_q.size() == 0 && bus.fill == 0 && !bus.wr_en) break;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic next_base();
    smp_base = smp_base + 16'h0010;
  endtask

  int base_data;

  initial begin
    bus.req_data = 1'b0;
    bus.sel      = 3'd0;
    bus.ch_data  = '0;
    bus.wr_full  = 1'b0;
    bus.clr_ovf  = 1'b0;
    tick();
    tick();
    check_eq("rst_wr_en", bus.wr_en, 0);
    check_eq("rst_wr_sop", bus.wr_sop, 0);
    check_eq("rst_wr_data", bus.wr_data, 0);
    check_eq("rst_ovf", bus.ovf, 0);
    check_eq("rst_ovf_cnt", bus.ovf_cnt, 0);
    check_eq("rst_fill", bus.fill, 0);
    reset_n = 1'b1;

    // Basic 4-sample burst
    max_run   = 0;
    base_data = n_data;
    for (int i = 0; i < 4; i++) push_sample(3'(i), 16'h1000, 1'b1);
    wait_drain("burst");
    check_eq("burst_words", n_data - base_data, 4);
`ifdef CH_PACK_SEQ_EN
    check_eq("burst_consecutive", max_run, 5);
`else
    check_eq("burst_consecutive", max_run, 4);
`endif

    // Overrun with downstream full, then drain and clear
    bus.wr_full = 1'b1;
    base_data   = n_data;
    for (int i = 0; i < 40; i++) begin
      push_sample(3'(i % 8), smp_base, i < 32);
      next_base();
    end
    idle(3);
    check_eq("ovr_fill", bus.fill, 32);
    check_eq("ovr_ovf", bus.ovf, 1);
    check_eq("ovr_ovf_cnt", bus.ovf_cnt, 8);
    check_eq("ovr_no_write", n_data - base_data, 0);
    bus.wr_full = 1'b0;
    wait_drain("ovr");
    check_eq("ovr_words", n_data - base_data, 32);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check_eq("clr_ovf", bus.ovf, 0);
    check_eq("clr_ovf_cnt", bus.ovf_cnt, 0);

    // Continuous 8-channel bursts; packet framing every PKT words
    base_data = n_data;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) push_sample(3'(k), smp_base, 1'b1);
      next_base();
    end
    wait_drain("cont");
    check_eq("cont_words", n_data - base_data, 32);

    // wr_full toggling while pushing
    base_data = n_data;
    for (int i = 0; i < 24; i++) begin
      bus.wr_full = (i % 2) == 1;
      push_sample(3'((i * 3) % 8), smp_base, 1'b1);
      next_base();
    end
    bus.wr_full = 1'b0;
    wait_drain("toggle");
    check_eq("toggle_words", n_data - base_data, 24);
    check_eq("toggle_ovf", bus.ovf, 0);

    // Mid-packet reset with 10 words buffered
    bus.wr_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_sample(3'(i % 8), smp_base, 1'b1);
      next_base();
    end
    idle(2);
    check_eq("pre_rst_fill", bus.fill, 10);
    reset_n = 1'b0;
    exp_q.delete();
    exp_pkt = 0;
    exp_seq = 8'h00;
    tick();
    check_eq("mid_rst_fill", bus.fill, 0);
    check_eq("mid_rst_wr_en", bus.wr_en, 0);
    check_eq("mid_rst_wr_sop", bus.wr_sop, 0);
    check_eq("mid_rst_wr_data", bus.wr_data, 0);
    check_eq("mid_rst_ovf_cnt", bus.ovf_cnt, 0);
    reset_n     = 1'b1;
    bus.wr_full = 1'b0;
    base_data   = n_data;
    for (int i = 0; i < 3; i++) begin
      push_sample(3'(i + 4), smp_base, 1'b1);
      next_base();
    end
    wait_drain("post_rst");
    check_eq("post_rst_words", n_data - base_data, 3);

    // Drop coincident with clr_ovf
    bus.wr_full = 1'b1;
    base_data   = n_data;
    for (int i = 0; i < 32; i++) begin
      push_sample(3'(i % 8), smp_base, 1'b1);
      next_base();
    end
    push_sample(3'd1, smp_base, 1'b0);
    next_base();
    push_sample(3'd2, smp_base, 1'b0);
    next_base();
    check_eq("drop_ovf", bus.ovf, 1);
    check_eq("drop_ovf_cnt", bus.ovf_cnt, 1);
    bus.req_data = 1'b0;
    bus.clr_ovf  = 1'b1;
    tick();
    bus.clr_ovf  = 1'b0;
    check_eq("clr_win_ovf", bus.ovf, 0);
    check_eq("clr_win_ovf_cnt", bus.ovf_cnt, 0);
    check_eq("clr_win_fill", bus.fill, 32);
    bus.wr_full = 1'b0;
    wait_drain("clr_win");
    check_eq("clr_win_words", n_data - base_data, 32);
    check_eq("clr_win_ovf_end", bus.ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
